apb_gpio_param: RTL and testbench

APB_GPIO_PARAM -- requirements
Module: apb_gpio_param

---
 rtl/apb_gpio_pkg.sv | 32 +++
 rtl/apb_gpio_param_if.sv | 24 ++
 rtl/gpio_sync_edge.sv | 40 ++++
 rtl/apb_gpio_param.sv | 166 ++++++++++++++++
 tb/tb_apb_gpio_param.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_gpio_pkg.sv
// rtl/apb_gpio_pkg.sv - register map, address limit and interrupt mode encodings for the APB GPIO block
package apb_gpio_pkg;

    localparam logic [4:0] ADDR_DATA_IN    = 5'h00;
    localparam logic [4:0] ADDR_DATA_OUT   = 5'h04;
    localparam logic [4:0] ADDR_DIR        = 5'h08;
    localparam logic [4:0] ADDR_IRQ_EN     = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_TYPE   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_POL    = 5'h14;
    localparam logic [4:0] ADDR_IRQ_STATUS = 5'h18;
    localparam logic [4:0] ADDR_MAX        = 5'h18;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_type_e;

    typedef enum logic {
        IRQ_POL_LOW  = 1'b0,
        IRQ_POL_HIGH = 1'b1
    } irq_pol_e;

    // Expands the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_gpio_param_if.sv
// rtl/apb_gpio_param_if.sv - APB bus bundle for the GPIO block, master and slave views
interface apb_gpio_param_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - multi-stage pin synchronizer with one-cycle edge history
module gpio_sync_edge #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] prev_q;
    logic         armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q  <= stage_q[STAGES-1];
            armed_q <= 1'b1;
        end
    end

    // armed_q masks the history comparison during the first cycle out of reset.
    assign sync_o = stage_q[STAGES-1];
    assign rise_o = {W{armed_q}} & sync_o & ~prev_q;
    assign fall_o = {W{armed_q}} & ~sync_o & prev_q;

endmodule

// File: rtl/apb_gpio_param.sv
// rtl/apb_gpio_param.sv - APB GPIO with synchronized inputs and per-pin interrupts
// Interrupt registers and IRQ_O exist only when GPIO_IRQ_EN is defined.
module apb_gpio_param
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_gpio_param_if.slave   apb,
    input  logic [GPIO_W-1:0] GPIO_I,
    output logic [GPIO_W-1:0] GPIO_O,
    output logic [GPIO_W-1:0] GPIO_OE,
    output logic              IRQ_O
);

    logic              acc_phase;
    logic              addr_bad;
    logic              bus_err;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       mask32;
    logic [GPIO_W-1:0] lane_mask;
    logic [GPIO_W-1:0] wdata_w;
    logic [GPIO_W-1:0] data_in;
    logic [GPIO_W-1:0] edge_rise;
    logic [GPIO_W-1:0] edge_fall;
    logic [GPIO_W-1:0] data_out_q, data_out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] irq_en_rd;
    logic [GPIO_W-1:0] irq_type_rd;
    logic [GPIO_W-1:0] irq_pol_rd;
    logic [GPIO_W-1:0] irq_status_rd;
    logic [31:0]       rdata_ext;

    gpio_sync_edge #(
        .W      (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .din_i  (GPIO_I),
        .sync_o (data_in),
        .rise_o (edge_rise),
        .fall_o (edge_fall)
    );

    assign acc_phase = apb.PSEL & apb.PENABLE;
    assign addr_bad  = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR > ADDR_MAX);
    assign bus_err   = acc_phase & (addr_bad | (apb.PWRITE & (apb.PADDR == ADDR_DATA_IN)));
    assign wr_en     = acc_phase & apb.PWRITE & ~bus_err;
    assign rd_en     = acc_phase & ~apb.PWRITE & ~bus_err;

    // Lanes and data above GPIO_W are dropped here so no register ever holds them.
    assign mask32    = strb_to_mask(apb.PSTRB);
    assign lane_mask = mask32[GPIO_W-1:0];
    assign wdata_w   = apb.PWDATA[GPIO_W-1:0];

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (wr_en && (apb.PADDR == ADDR_DATA_OUT)) begin
            data_out_d = (data_out_q & ~lane_mask) | (wdata_w & lane_mask);
        end
        if (wr_en && (apb.PADDR == ADDR_DIR)) begin
            dir_d = (dir_q & ~lane_mask) | (wdata_w & lane_mask);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            data_out_q <= '0;
            dir_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

    assign GPIO_O  = data_out_q;
    assign GPIO_OE = dir_q;

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] irq_en_q, irq_en_d;
    logic [GPIO_W-1:0] irq_type_q, irq_type_d;
    logic [GPIO_W-1:0] irq_pol_q, irq_pol_d;
    logic [GPIO_W-1:0] irq_status_q, irq_status_d;
    logic [GPIO_W-1:0] irq_set;
    logic [GPIO_W-1:0] irq_clr;

    always_comb begin
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;
        irq_set    = '0;
        irq_clr    = '0;
        if (wr_en) begin
            case (apb.PADDR)
                ADDR_IRQ_EN:     irq_en_d   = (irq_en_q   & ~lane_mask) | (wdata_w & lane_mask);
                ADDR_IRQ_TYPE:   irq_type_d = (irq_type_q & ~lane_mask) | (wdata_w & lane_mask);
                ADDR_IRQ_POL:    irq_pol_d  = (irq_pol_q  & ~lane_mask) | (wdata_w & lane_mask);
                ADDR_IRQ_STATUS: irq_clr    = wdata_w & lane_mask;
                default: ;
            endcase
        end
        for (int i = 0; i < GPIO_W; i++) begin
            if (irq_type_q[i] == IRQ_EDGE) begin
                irq_set[i] = (irq_pol_q[i] == IRQ_POL_HIGH) ? edge_rise[i] : edge_fall[i];
            end else begin
                irq_set[i] = (data_in[i] == irq_pol_q[i]);
            end
        end
        // A new event wins over a clear landing on the same edge.
        irq_status_d = (irq_status_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
        end else begin
            irq_en_q     <= irq_en_d;
            irq_type_q   <= irq_type_d;
            irq_pol_q    <= irq_pol_d;
            irq_status_q <= irq_status_d;
        end
    end

    assign irq_en_rd     = irq_en_q;
    assign irq_type_rd   = irq_type_q;
    assign irq_pol_rd    = irq_pol_q;
    assign irq_status_rd = irq_status_q;
    assign IRQ_O         = |(irq_status_q & irq_en_q);
`else
    logic unused_edges;

    assign unused_edges  = ^{edge_rise, edge_fall};
    assign irq_en_rd     = '0;
    assign irq_type_rd   = '0;
    assign irq_pol_rd    = '0;
    assign irq_status_rd = '0;
    assign IRQ_O         = 1'b0;
`endif

    always_comb begin
        rdata_ext = '0;
        case (apb.PADDR)
            ADDR_DATA_IN:    rdata_ext[GPIO_W-1:0] = data_in;
            ADDR_DATA_OUT:   rdata_ext[GPIO_W-1:0] = data_out_q;
            ADDR_DIR:        rdata_ext[GPIO_W-1:0] = dir_q;
            ADDR_IRQ_EN:     rdata_ext[GPIO_W-1:0] = irq_en_rd;
            ADDR_IRQ_TYPE:   rdata_ext[GPIO_W-1:0] = irq_type_rd;
            ADDR_IRQ_POL:    rdata_ext[GPIO_W-1:0] = irq_pol_rd;
            ADDR_IRQ_STATUS: rdata_ext[GPIO_W-1:0] = irq_status_rd;
            default: ;
        endcase
    end

    assign apb.PRDATA  = rd_en ? rdata_ext : 32'h0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = bus_err;

endmodule

// File: tb/tb_apb_gpio_param.sv
// tb/tb_apb_gpio_param.sv - scoreboard bench for apb_gpio_param at 32-bit and 8-bit widths
module tb_apb_gpio_param;

`ifdef GPIO_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    localparam logic [4:0] A_IN   = 5'h00;
    localparam logic [4:0] A_OUT  = 5'h04;
    localparam logic [4:0] A_DIR  = 5'h08;
    localparam logic [4:0] A_EN   = 5'h0C;
    localparam logic [4:0] A_TYPE = 5'h10;
    localparam logic [4:0] A_POL  = 5'h14;
    localparam logic [4:0] A_STAT = 5'h18;

    typedef struct {
        bit          is_probe;
        bit          sel8;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] gpo;
        logic [31:0] oe;
        bit          irq;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o, gpio_oe;
    logic        irq_o;
    logic [7:0]  gpio_i8 = '0;
    logic [7:0]  gpio_o8, gpio_oe8;
    logic        irq_o8;
    bit          probe_on = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    apb_gpio_param_if aif ();
    apb_gpio_param_if aif8 ();

    apb_gpio_param #(.GPIO_W(32), .SYNC_STAGES(2)) dut (
        .PCLK(clk), .PRESET(rst), .apb(aif),
        .GPIO_I(gpio_i), .GPIO_O(gpio_o), .GPIO_OE(gpio_oe), .IRQ_O(irq_o)
    );

    apb_gpio_param #(.GPIO_W(8), .SYNC_STAGES(2)) dut8 (
        .PCLK(clk), .PRESET(rst), .apb(aif8),
        .GPIO_I(gpio_i8), .GPIO_O(gpio_o8), .GPIO_OE(gpio_oe8), .IRQ_O(irq_o8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (probe_on || (aif.PSEL && aif.PENABLE) || (aif8.PSEL && aif8.PENABLE)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: bus active with empty scoreboard");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_probe) begin
                    check({mon_e.name, "_gpo"}, mon_e.sel8 ? {24'h0, gpio_o8} : gpio_o, mon_e.gpo);
                    check({mon_e.name, "_oe"}, mon_e.sel8 ? {24'h0, gpio_oe8} : gpio_oe, mon_e.oe);
                    check({mon_e.name, "_irq"}, {31'h0, mon_e.sel8 ? irq_o8 : irq_o}, {31'h0, mon_e.irq});
                end else if (mon_e.sel8) begin
                    check({mon_e.name, "_bus"}, {31'h0, aif8.PSEL & aif8.PENABLE}, 32'h1);
                    check({mon_e.name, "_rdata"}, aif8.PRDATA, mon_e.rdata);
                    check({mon_e.name, "_err"}, {31'h0, aif8.PSLVERR}, {31'h0, mon_e.err});
                    check({mon_e.name, "_ready"}, {31'h0, aif8.PREADY}, 32'h1);
                end else begin
                    check({mon_e.name, "_bus"}, {31'h0, aif.PSEL & aif.PENABLE}, 32'h1);
                    check({mon_e.name, "_rdata"}, aif.PRDATA, mon_e.rdata);
                    check({mon_e.name, "_err"}, {31'h0, aif.PSLVERR}, {31'h0, mon_e.err});
                    check({mon_e.name, "_ready"}, {31'h0, aif.PREADY}, 32'h1);
                end
            end
        end
    end

    task automatic bus_drive(input bit sel8, input logic psel, input logic pen, input logic pwr,
                             input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        if (sel8) begin
            aif8.PSEL = psel; aif8.PENABLE = pen; aif8.PWRITE = pwr;
            aif8.PADDR = addr; aif8.PWDATA = wd; aif8.PSTRB = strb;
        end else begin
            aif.PSEL = psel; aif.PENABLE = pen; aif.PWRITE = pwr;
            aif.PADDR = addr; aif.PWDATA = wd; aif.PSTRB = strb;
        end
    endtask

    task automatic apb(input bit sel8, input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input bit exp_err,
                       input string name);
        exp_t e;
        e.is_probe = 1'b0; e.sel8 = sel8; e.rdata = exp_rdata; e.err = exp_err;
        e.gpo = '0; e.oe = '0; e.irq = 1'b0; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus_drive(sel8, 1'b1, 1'b0, wr, addr, wd, strb);
        @(posedge clk); #1;
        bus_drive(sel8, 1'b1, 1'b1, wr, addr, wd, strb);
        @(posedge clk); #1;
        bus_drive(sel8, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] strb, input string name);
        apb(1'b0, 1'b1, addr, wd, strb, 32'h0, 1'b0, name);
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        apb(1'b0, 1'b0, addr, 32'h0, 4'h0, exp, 1'b0, name);
    endtask

    task automatic probe_pins(input bit sel8, input logic [31:0] gpo, input logic [31:0] oe,
                              input bit irq, input string name);
        exp_t e;
        e.is_probe = 1'b1; e.sel8 = sel8; e.rdata = '0; e.err = 1'b0;
        e.gpo = gpo; e.oe = oe; e.irq = irq; e.name = name;
        exp_q.push_back(e);
        probe_on = 1'b1;
        @(negedge clk); #1;
        probe_on = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_drive(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        bus_drive(1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        probe_pins(1'b0, 32'h0, 32'h0, 1'b0, "reset_pins");
        rd(A_OUT, 32'h0, "reset_data_out");
        rd(A_DIR, 32'h0, "reset_dir");
        rd(A_EN, 32'h0, "reset_irq_en");

        wr(A_OUT, 32'hA5A5_A5A5, 4'b0011, "w_out_strb");
        rd(A_OUT, 32'h0000_A5A5, "r_out_strb");
        wr(A_DIR, 32'h00FF_00FF, 4'hF, "w_dir");
        rd(A_DIR, 32'h00FF_00FF, "r_dir");
        probe_pins(1'b0, 32'h0000_A5A5, 32'h00FF_00FF, 1'b0, "pins_after_write");

        apb(1'b0, 1'b1, A_IN, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "err_w_data_in");
        apb(1'b0, 1'b0, 5'h1C, 32'h0, 4'h0, 32'h0, 1'b1, "err_r_1c");
        apb(1'b0, 1'b1, 5'h06, 32'h0, 4'hF, 32'h0, 1'b1, "err_w_06");
        apb(1'b0, 1'b0, 5'h06, 32'h0, 4'h0, 32'h0, 1'b1, "err_r_06");
        rd(A_OUT, 32'h0000_A5A5, "out_unchanged");
        rd(A_DIR, 32'h00FF_00FF, "dir_unchanged");

        gpio_i = 32'hFFFF_FFF7;
        repeat (3) @(posedge clk);
        #1;
        rd(A_IN, 32'hFFFF_FFF7, "data_in");

        wr(A_TYPE, 32'h8, 4'hF, "w_type");
        wr(A_POL, 32'h8, 4'hF, "w_pol");
        wr(A_EN, 32'h8, 4'hF, "w_en");
        wr(A_STAT, 32'hFFFF_FFFF, 4'hF, "w1c_all");
        rd(A_TYPE, HAS_IRQ ? 32'h8 : 32'h0, "r_type");
        rd(A_STAT, 32'h0, "stat_clean");

        gpio_i = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk); #1;
        probe_pins(1'b0, 32'h0000_A5A5, 32'h00FF_00FF, 1'b0, "irq_before_edge");
        @(posedge clk); #1;
        probe_pins(1'b0, 32'h0000_A5A5, 32'h00FF_00FF, HAS_IRQ, "irq_at_edge");
        rd(A_STAT, HAS_IRQ ? 32'h8 : 32'h0, "stat_edge");
        wr(A_STAT, 32'h8, 4'hF, "w1c_edge");
        probe_pins(1'b0, 32'h0000_A5A5, 32'h00FF_00FF, 1'b0, "irq_cleared");

        wr(A_POL, 32'h9, 4'hF, "w_pol_level");
        rd(A_STAT, HAS_IRQ ? 32'h1 : 32'h0, "stat_level");
        wr(A_STAT, 32'h1, 4'hF, "w1c_level_held");
        rd(A_STAT, HAS_IRQ ? 32'h1 : 32'h0, "stat_level_reset");
        gpio_i = 32'hFFFF_FFFE;
        repeat (4) @(posedge clk);
        #1;
        wr(A_STAT, 32'h1, 4'hF, "w1c_level_released");
        rd(A_STAT, 32'h0, "stat_level_gone");

        gpio_i = 32'hFFFF_FFF6;
        repeat (4) @(posedge clk);
        #1;
        wr(A_STAT, 32'h8, 4'hF, "w1c_prep");
        rd(A_STAT, 32'h0, "stat_prep");
        gpio_i = 32'hFFFF_FFFE;
        wr(A_STAT, 32'h8, 4'hF, "w1c_collide");
        rd(A_STAT, HAS_IRQ ? 32'h8 : 32'h0, "stat_set_wins");
        probe_pins(1'b0, 32'h0000_A5A5, 32'h00FF_00FF, HAS_IRQ, "irq_set_wins");

        apb(1'b1, 1'b1, A_DIR, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, "w8_dir");
        apb(1'b1, 1'b0, A_DIR, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, "r8_dir");
        apb(1'b1, 1'b1, A_OUT, 32'h0000_12A5, 4'hF, 32'h0, 1'b0, "w8_out");
        apb(1'b1, 1'b0, A_OUT, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, "r8_out");
        probe_pins(1'b1, 32'h0000_00A5, 32'h0000_00FF, 1'b0, "pins8");

        fork
            apb(1'b1, 1'b1, A_OUT, 32'h0000_005A, 4'hF, 32'h0, 1'b0, "w8_reset_mid");
            begin
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        apb(1'b1, 1'b0, A_OUT, 32'h0, 4'h0, 32'h0, 1'b0, "r8_out_after_reset");
        apb(1'b1, 1'b0, A_DIR, 32'h0, 4'h0, 32'h0, 1'b0, "r8_dir_after_reset");
        rd(A_OUT, 32'h0, "out_after_reset");
        probe_pins(1'b0, 32'h0, 32'h0, 1'b0, "pins_after_reset");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
